gate_bist_checker: RTL and testbench

Synthesizable stimulus-and-response checker for the two-input basic-gate block. It drives the gate block's a/b inputs and receives its seven outputs. It steps through all four input vectors, waits a settle time, and compares the sampled outputs against a golden truth table. It replaces the simulation-only monitor with an on-chip pass/fail result, plus an error count and a per-vector failure mask.

---
 rtl/gate_chk_pkg.sv | 29 ++
 rtl/gate_golden_rom.sv | 20 ++
 rtl/gate_bist_checker.sv | 166 ++++++++++++++++
 tb/tb_gate_bist_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the two-input gate BIST checker.
// gate_out packing is {and, or, not_a, nand, nor, xor, xnor}, bit 6 down to bit 0.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] GOLD_00 = 7'h1D;
    localparam logic [6:0] GOLD_01 = 7'h3A;
    localparam logic [6:0] GOLD_10 = 7'h2A;
    localparam logic [6:0] GOLD_11 = 7'h61;

    localparam int AND_B   = 6;
    localparam int OR_B    = 5;
    localparam int NOT_A_B = 4;
    localparam int NAND_B  = 3;
    localparam int NOR_B   = 2;
    localparam int XOR_B   = 1;
    localparam int XNOR_B  = 0;

    function automatic logic [3:0] vec_onehot(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

endpackage

// File: rtl/gate_golden_rom.sv
// Combinational golden truth table: vector {a,b} -> expected gate_out.
module gate_golden_rom
    import gate_chk_pkg::*;
(
    input  logic [1:0] vec,
    output logic [6:0] expected
);

    always_comb begin
        expected = GOLD_00;
        case (vec)
            2'd0: expected = GOLD_00;
            2'd1: expected = GOLD_01;
            2'd2: expected = GOLD_10;
            2'd3: expected = GOLD_11;
            default: expected = GOLD_00;
        endcase
    end

endmodule

// File: rtl/gate_bist_checker.sv
// On-chip stimulus/response checker for the basic-gate block; done rises 4*(SETTLE+1) cycles after start.
// Define GATE_CHK_FAIL_CAPTURE_EN to add first-failure capture ports fail_vec/fail_obs.
module gate_bist_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       gate_out,
    output logic             stim_a,
    output logic             stim_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       fail_mask
`ifdef GATE_CHK_FAIL_CAPTURE_EN
    ,
    output logic [1:0]       fail_vec,
    output logic [6:0]       fail_obs
`endif
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t           state, state_nxt;
    logic [1:0]       vec, vec_nxt;
    logic [7:0]       settle_cnt, settle_nxt;
    logic             stim_a_nxt, stim_b_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic [CNT_W-1:0] err_nxt, err_chk;
    logic [3:0]       mask_nxt, mask_chk;
    logic [6:0]       expected;
    logic             mismatch;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
    logic [1:0]       fail_vec_nxt;
    logic [6:0]       fail_obs_nxt;
`endif

    gate_golden_rom u_rom (
        .vec      (vec),
        .expected (expected)
    );

    // Result update for the current vector; only committed in CHECK.
    always_comb begin
        mismatch = (gate_out != expected);
        err_chk  = err_cnt;
        mask_chk = fail_mask;
        if (mismatch) begin
            if (err_cnt != '1)
                err_chk = err_cnt + CNT_W'(1);
            mask_chk = fail_mask | vec_onehot(vec);
        end
    end

    always_comb begin
        state_nxt  = state;
        vec_nxt    = vec;
        settle_nxt = settle_cnt;
        stim_a_nxt = stim_a;
        stim_b_nxt = stim_b;
        busy_nxt   = busy;
        done_nxt   = done;
        pass_nxt   = pass;
        err_nxt    = err_cnt;
        mask_nxt   = fail_mask;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
        fail_vec_nxt = fail_vec;
        fail_obs_nxt = fail_obs;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = DRIVE;
                    vec_nxt    = 2'd0;
                    settle_nxt = 8'd0;
                    stim_a_nxt = 1'b0;
                    stim_b_nxt = 1'b0;
                    busy_nxt   = 1'b1;
                    done_nxt   = 1'b0;
                    pass_nxt   = 1'b0;
                    err_nxt    = '0;
                    mask_nxt   = 4'd0;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
                    fail_vec_nxt = 2'd0;
                    fail_obs_nxt = 7'd0;
`endif
                end
            end
            DRIVE: begin
                if (settle_cnt == SETTLE_LAST)
                    state_nxt = CHECK;
                else
                    settle_nxt = settle_cnt + 8'd1;
            end
            CHECK: begin
                err_nxt  = err_chk;
                mask_nxt = mask_chk;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
                // A zero error count means this is the run's first mismatch.
                if (mismatch && (err_cnt == '0)) begin
                    fail_vec_nxt = vec;
                    fail_obs_nxt = gate_out;
                end
`endif
                if (vec == 2'd3) begin
                    state_nxt  = DONE;
                    stim_a_nxt = 1'b0;
                    stim_b_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
                    pass_nxt   = (err_chk == '0);
                end else begin
                    state_nxt  = DRIVE;
                    vec_nxt    = vec + 2'd1;
                    settle_nxt = 8'd0;
                    stim_a_nxt = vec_nxt[1];
                    stim_b_nxt = vec_nxt[0];
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 2'd0;
            settle_cnt <= 8'd0;
            stim_a     <= 1'b0;
            stim_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_mask  <= 4'd0;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
            fail_vec   <= 2'd0;
            fail_obs   <= 7'd0;
`endif
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            settle_cnt <= settle_nxt;
            stim_a     <= stim_a_nxt;
            stim_b     <= stim_b_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_cnt    <= err_nxt;
            fail_mask  <= mask_nxt;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
            fail_vec   <= fail_vec_nxt;
            fail_obs   <= fail_obs_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench: SETTLE=2 checker driven by a faultable gate model, plus a SETTLE=1 checker with noisy gate_out.
module tb_gate_bist_checker;
    import gate_chk_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] gold_tbl [4];

    // DUT 1: SETTLE=2, fed by the behavioural gate model
    logic       start1 = 1'b0;
    logic [6:0] gate_out1;
    logic       stim_a1, stim_b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] mask1;
    logic [1:0] fault = 2'd0;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
    logic [1:0] fvec1, fvec2;
    logic [6:0] fobs1, fobs2;
`endif

    // DUT 2: SETTLE=1, gate_out driven directly by the bench
    logic       start2 = 1'b0;
    logic [6:0] gate_out2 = 7'h00;
    logic       stim_a2, stim_b2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [3:0] mask2;

    logic [1:0] rom_vec = 2'd0;
    logic [6:0] rom_exp;

    gate_bist_checker #(.SETTLE(2), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate_out(gate_out1),
        .stim_a(stim_a1), .stim_b(stim_b1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1), .fail_mask(mask1)
`ifdef GATE_CHK_FAIL_CAPTURE_EN
        , .fail_vec(fvec1), .fail_obs(fobs1)
`endif
    );

    gate_bist_checker #(.SETTLE(1), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .gate_out(gate_out2),
        .stim_a(stim_a2), .stim_b(stim_b2), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(err2), .fail_mask(mask2)
`ifdef GATE_CHK_FAIL_CAPTURE_EN
        , .fail_vec(fvec2), .fail_obs(fobs2)
`endif
    );

    gate_golden_rom u_rom (.vec(rom_vec), .expected(rom_exp));

    // fault: 0 none, 1 xor stuck-at-0, 2 and stuck-at-1, 3 all outputs inverted
    function automatic logic [6:0] gate_model(input logic a, input logic b, input logic [1:0] f);
        logic [6:0] g;
        g = {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
        case (f)
            2'd1: g[1] = 1'b0;
            2'd2: g[6] = 1'b1;
            2'd3: g = ~g;
            default: ;
        endcase
        return g;
    endfunction

    always_comb gate_out1 = gate_model(stim_a1, stim_b1, fault);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] fault;
        bit         pulse_mid;
        bit         pulse_done;
        logic       pass;
        logic [2:0] err;
        logic [3:0] mask;
        logic [1:0] fvec;
        logic [6:0] fobs;
    } run_t;

    localparam int NRUNS = 7;
    run_t runs [NRUNS];

    // Start at edge E: stim steps every 3 cycles, done is set by edge E+12 (seen at E+13).
    task automatic apply_run(input run_t r, input string tag);
        fault = r.fault;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        @(negedge clk) start1 = 1'b0;
        chk({tag, " busy after start"}, 32'(busy1), 32'd1);
        chk({tag, " done cleared"},     32'(done1), 32'd0);
        chk({tag, " err cleared"},      32'(err1),  32'd0);
        chk({tag, " mask cleared"},     32'(mask1), 32'd0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start1 = (r.pulse_mid && (k == 3 || k == 7)) || (r.pulse_done && k == 11);
            chk($sformatf("%s stim k%0d", tag, k), 32'({stim_a1, stim_b1}), 32'(k / 3));
            if (k == 11) begin
                chk({tag, " done early"}, 32'(done1), 32'd0);
                chk({tag, " busy late"},  32'(busy1), 32'd1);
            end
        end
        @(negedge clk) start1 = 1'b0;
        chk({tag, " done"},      32'(done1), 32'd1);
        chk({tag, " busy end"},  32'(busy1), 32'd0);
        chk({tag, " pass"},      32'(pass1), 32'(r.pass));
        chk({tag, " err_cnt"},   32'(err1),  32'(r.err));
        chk({tag, " fail_mask"}, 32'(mask1), 32'(r.mask));
        chk({tag, " stim idle"}, 32'({stim_a1, stim_b1}), 32'd0);
`ifdef GATE_CHK_FAIL_CAPTURE_EN
        chk({tag, " fail_vec"}, 32'(fvec1), 32'(r.fvec));
        chk({tag, " fail_obs"}, 32'(fobs1), 32'(r.fobs));
`endif
        @(negedge clk);
        chk({tag, " done held"}, 32'(done1), 32'd1);
        chk({tag, " idle held"}, 32'(busy1), 32'd0);
        chk({tag, " err held"},  32'(err1),  32'(r.err));
    endtask

    // SETTLE=1: CHECK samples at edges E+2,4,6,8; every other cycle gets a wrong gate_out.
    task automatic run_noisy(input int bad_vec, input logic exp_pass, input logic [2:0] exp_err,
                             input logic [3:0] exp_mask, input string tag);
        @(negedge clk);
        start2    = 1'b1;
        gate_out2 = 7'($urandom_range(0, 127));
        @(posedge clk);
        @(negedge clk) start2 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k % 2 == 0) begin
                gate_out2 = gold_tbl[k / 2 - 1];
                if (k / 2 - 1 == bad_vec)
                    gate_out2 = gate_out2 ^ 7'h04;
            end else begin
                gate_out2 = gold_tbl[(k - 1) / 2] ^ 7'($urandom_range(1, 127));
            end
            @(negedge clk);
            if (k == 7)
                chk({tag, " done early"}, 32'(done2), 32'd0);
        end
        gate_out2 = 7'($urandom_range(0, 127));
        chk({tag, " done"},      32'(done2), 32'd1);
        chk({tag, " busy end"},  32'(busy2), 32'd0);
        chk({tag, " pass"},      32'(pass2), 32'(exp_pass));
        chk({tag, " err_cnt"},   32'(err2),  32'(exp_err));
        chk({tag, " fail_mask"}, 32'(mask2), 32'(exp_mask));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        gold_tbl[0] = 7'h1D;
        gold_tbl[1] = 7'h3A;
        gold_tbl[2] = 7'h2A;
        gold_tbl[3] = 7'h61;
        //           fault mid done  pass err   mask     fvec  fobs
        runs[0] = '{2'd0, 0, 0, 1'b1, 3'd0, 4'b0000, 2'd0, 7'h00};
        runs[1] = '{2'd1, 0, 0, 1'b0, 3'd2, 4'b0110, 2'd1, 7'h38};
        runs[2] = '{2'd1, 1, 1, 1'b0, 3'd2, 4'b0110, 2'd1, 7'h38};
        runs[3] = '{2'd0, 0, 0, 1'b1, 3'd0, 4'b0000, 2'd0, 7'h00};
        runs[4] = '{2'd2, 0, 0, 1'b0, 3'd3, 4'b0111, 2'd0, 7'h5D};
        runs[5] = '{2'd3, 0, 0, 1'b0, 3'd4, 4'b1111, 2'd0, 7'h62};
        runs[6] = '{2'd0, 0, 1, 1'b1, 3'd0, 4'b0000, 2'd0, 7'h00};

        // Reset with no clock edge yet
        #1 rst = 1'b1;
        #2;
        chk("reset busy",  32'(busy1), 32'd0);
        chk("reset done",  32'(done1), 32'd0);
        chk("reset pass",  32'(pass1), 32'd0);
        chk("reset err",   32'(err1),  32'd0);
        chk("reset mask",  32'(mask1), 32'd0);
        chk("reset stim",  32'({stim_a1, stim_b1}), 32'd0);
        chk("reset busy2", 32'(busy2), 32'd0);
        for (int v = 0; v < 4; v++) begin
            rom_vec = 2'(v);
            #1;
            chk($sformatf("rom vec%0d", v), 32'(rom_exp), 32'(gold_tbl[v]));
        end
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < NRUNS; i++)
            apply_run(runs[i], $sformatf("run%0d", i));

        // Abort a faulty run at vec=2, after vec1 has already failed
        fault = 2'd1;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        @(negedge clk) start1 = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort pre stim", 32'({stim_a1, stim_b1}), 32'd2);
        chk("abort pre err",  32'(err1), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy1), 32'd0);
        chk("abort done", 32'(done1), 32'd0);
        chk("abort pass", 32'(pass1), 32'd0);
        chk("abort err",  32'(err1),  32'd0);
        chk("abort mask", 32'(mask1), 32'd0);
        chk("abort stim", 32'({stim_a1, stim_b1}), 32'd0);
`ifdef GATE_CHK_FAIL_CAPTURE_EN
        chk("abort fail_vec", 32'(fvec1), 32'd0);
        chk("abort fail_obs", 32'(fobs1), 32'd0);
`endif
        @(negedge clk) rst = 1'b0;
        apply_run(runs[0], "post_abort");

        run_noisy(-1, 1'b1, 3'd0, 4'b0000, "s1 clean");
        run_noisy(3,  1'b0, 3'd1, 4'b1000, "s1 vec3 bad");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
